ram_burst_master: RTL

Initiator for the 8-bit x 32-word single-port RAM's data/addr/we/read/full/q interface. It runs in two phases.
- Fill: accepts a valid/ready byte stream and writes it to sequential RAM addresses starting at 0.
- Dump: on command, reads the stored words back in order and presents them on a valid/ready output stream, with the RAM read mode applied.
- Sits between a producer/consumer datapath and single_port_ram. It replaces hand-driven write/read sequencing.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_burst_master_if.sv | 25 ++
 rtl/ram_rd_stage.sv | 44 ++++
 rtl/ram_burst_master.sv | 111 +++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and encodings for the single-port RAM burst master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_pkg;

    localparam int RAM_DW    = 8;
    localparam int RAM_AW    = 5;
    localparam int RAM_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_M1   = 3'b001;
    localparam logic [2:0] RD_M2   = 3'b010;
    localparam logic [2:0] RD_M4   = 3'b100;
    localparam logic [2:0] RD_ALL  = 3'b111;

endpackage

// File: rtl/ram_burst_master_if.sv
// RAM-side bus between the burst master and single_port_ram.
// Latency: ram_q follows the address edge by one cycle.
// Backpressure: none; ram_full only stops the fill stream.
// Ports: ram_data/ram_addr/ram_we/ram_read from master; ram_q/ram_full from RAM.
interface ram_burst_master_if import ram_pkg::*; #(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
);
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [2:0]    ram_read;
    logic [DW-1:0] ram_q;
    logic          ram_full;

    modport master (
        output ram_data, ram_addr, ram_we, ram_read,
        input  ram_q, ram_full
    );

    modport slave (
        input  ram_data, ram_addr, ram_we, ram_read,
        output ram_q, ram_full
    );
endinterface

// File: rtl/ram_rd_stage.sv
// Single-entry output register for RAM read-back with one read in flight.
// Latency: ram_q captured into m_data the cycle after issue; 1 word / 2 cycles.
// Backpressure: m_data/m_valid hold until m_ready; no new read while a word waits.
// Ports: enable/more gate issue; issue/inflight report to the top; m_* is the stream.
module ram_rd_stage import ram_pkg::*; #(
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          more,
    input  logic [DW-1:0] ram_q,
    input  logic          m_ready,
    output logic          issue,
    output logic          inflight,
    output logic [DW-1:0] m_data,
    output logic          m_valid
);

    // A read may be launched on the same edge the current word is accepted,
    // so the slot is free again exactly when the RAM data arrives.
    assign issue = enable & ~inflight & (~m_valid | m_ready) & more;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (inflight) begin
                m_data   <= ram_q;
                m_valid  <= 1'b1;
                inflight <= 1'b0;
            end
            if (issue) begin
                inflight <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Fills the RAM from a byte stream at addresses 0.., then dumps the words back in order.
// Latency: writes land on the handshake edge; dump words appear 2 cycles after issue.
// Backpressure: s_ready drops at DEPTH words, on ram_full, in HOLD and DUMP; dump honours m_ready.
// Ports: clk/rst, s_* fill stream, start_dump/dump_mode, m_* dump stream, ram bus, count, busy.
module ram_burst_master import ram_pkg::*; #(
    parameter int DW    = RAM_DW,
    parameter int AW    = RAM_AW,
    parameter int DEPTH = RAM_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 start_dump,
    input  logic [2:0]           dump_mode,
    output logic [DW-1:0]        m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    ram_burst_master_if.master   ram,
    output logic [AW:0]          count,
    output logic                 busy
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_q;
    logic [2:0]  read_q;

    logic        wr_hs;
    logic [AW:0] count_nxt;
    logic        start_ok;
    logic        rd_more;
    logic        rd_issue;
    logic        rd_inflight;
    logic        last_acc;

    // wr_ptr is checked as well as count so no write can ever target >= DEPTH.
    assign s_ready   = (state == ST_FILL) & (count_q < DEPTH_C) & (wr_ptr < DEPTH_C) & ~ram.ram_full;
    assign wr_hs     = s_valid & s_ready;
    assign count_nxt = wr_hs ? count_q + ONE : count_q;
    // A write on the start_dump cycle counts, so a lone first word can start a dump.
    assign start_ok  = start_dump & (state != ST_DUMP) & (count_nxt != '0);
    assign rd_more   = rd_ptr < count_q;
    // Last word: every read has been issued, none pending, and the final word leaves.
    assign last_acc  = (state == ST_DUMP) & m_valid & m_ready & ~rd_inflight & ~rd_more;

    assign ram.ram_we   = wr_hs;
    assign ram.ram_data = s_data;
    assign ram.ram_addr = (state == ST_DUMP) ? rd_ptr[AW-1:0] : wr_ptr[AW-1:0];
    assign ram.ram_read = read_q;
    assign count        = count_q;
    assign busy         = (state == ST_DUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FILL;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            read_q  <= RD_NONE;
        end else begin
            case (state)
                ST_FILL, ST_HOLD: begin
                    if (wr_hs) begin
                        wr_ptr <= wr_ptr + ONE;
                    end
                    count_q <= count_nxt;
                    if (start_ok) begin
                        state  <= ST_DUMP;
                        read_q <= dump_mode;
                        rd_ptr <= '0;
                    end else if ((state == ST_FILL) && ((count_nxt == DEPTH_C) || ram.ram_full)) begin
                        state <= ST_HOLD;
                    end
                end
                ST_DUMP: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + ONE;
                    end
                    if (last_acc) begin
                        state   <= ST_FILL;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        count_q <= '0;
                        read_q  <= RD_NONE;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    ram_rd_stage #(.DW(DW)) u_rd_stage (
        .clk      (clk),
        .rst      (rst),
        .enable   (state == ST_DUMP),
        .more     (rd_more),
        .ram_q    (ram.ram_q),
        .m_ready  (m_ready),
        .issue    (rd_issue),
        .inflight (rd_inflight),
        .m_data   (m_data),
        .m_valid  (m_valid)
    );

endmodule
